window_gen_3x3: RTL and testbench

- Raster-to-window front end for the edge-preserving `filter`.
- Consumes one 8-bit luma pixel per valid cycle from the video input.
- Buffers two previous lines internally.
- Emits the 3x3 neighbourhood `sw_pixel_1..9` plus the `act` strobe that `filter` consumes, so it is the producer end of the `filter` window interface.
- Emits interior windows only. Border handling is downstream's concern unless the optional feature below is compiled in.

---
 rtl/window_gen_3x3_pkg.sv | 14 +
 rtl/window_gen_3x3_if.sv | 26 ++
 rtl/window_gen_3x3_line_buffer.sv | 23 ++
 rtl/window_gen_3x3.sv | 168 ++++++++++++++++
 tb/tb_window_gen_3x3.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_3x3_pkg.sv
// Shared constants and FSM state type for the 3x3 window generator.
// With WINDOW_BORDER_REPLICATE_EN defined, two extra states flush the border windows.
package window_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_SIZE  = 3;

`ifdef WINDOW_BORDER_REPLICATE_EN
  typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, TAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
`endif

endpackage

// File: rtl/window_gen_3x3_if.sv
// Window bus from the generator (master) to the filter (slave).
// act qualifies sw_pixel_1..9 for exactly one cycle; there is no ready, so the slave takes every strobe.
interface window_gen_3x3_if
  import window_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic             act;
  logic [PIX_W-1:0] sw_pixel_1, sw_pixel_2, sw_pixel_3;
  logic [PIX_W-1:0] sw_pixel_4, sw_pixel_5, sw_pixel_6;
  logic [PIX_W-1:0] sw_pixel_7, sw_pixel_8, sw_pixel_9;

  modport master (
    output act,
    output sw_pixel_1, sw_pixel_2, sw_pixel_3,
    output sw_pixel_4, sw_pixel_5, sw_pixel_6,
    output sw_pixel_7, sw_pixel_8, sw_pixel_9
  );

  modport slave (
    input act,
    input sw_pixel_1, sw_pixel_2, sw_pixel_3,
    input sw_pixel_4, sw_pixel_5, sw_pixel_6,
    input sw_pixel_7, sw_pixel_8, sw_pixel_9
  );
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// Single-port line store with combinational read; a write lands at the clock edge,
// so a same-cycle read at the written address still returns the old contents.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = PIX_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/window_gen_3x3.sv
// Raster-to-3x3-window front end: two line buffers plus a 3x3 shift window.
// Optional WINDOW_BORDER_REPLICATE_EN emits clamped border windows, one line plus one pixel late.
module window_gen_3x3
  import window_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  window_gen_3x3_if.master win,
  output logic             eof,
  output logic             busy,
  output state_t           dbg_state
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = WIN_SIZE * WIN_SIZE;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    col, cur_col;
  logic [RW-1:0]    row, cur_row;
  logic             restart, accept, last, step, body_out;
  logic [PIX_W-1:0] top, mid;
  logic [PIX_W-1:0] col_in [0:WIN_SIZE-1];
  logic [PIX_W-1:0] w      [0:NW-1];
  logic [PIX_W-1:0] sw     [0:NW-1];

  // A sof-qualified pixel is always (0,0), whatever the counters say.
  assign restart = pix_valid && sof;
  assign accept  = restart || (pix_valid && (state == FILL || state == STREAM));
  assign cur_col = restart ? '0 : col;
  assign cur_row = restart ? '0 : row;
  assign last    = accept && !restart && cur_row == ROW_LAST && cur_col == COL_LAST;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) lb0 (
    .clk(clk), .we(accept), .addr(cur_col), .wdata(pix_in), .rdata(mid)
  );
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) lb1 (
    .clk(clk), .we(accept), .addr(cur_col), .wdata(mid), .rdata(top)
  );

`ifdef WINDOW_BORDER_REPLICATE_EN
  logic             flush_step, tail_step, edge_out;
  logic [PIX_W-1:0] o [0:NW-1];

  // Flush walks a virtual row below the frame; TAIL emits the final right-edge window.
  assign flush_step = !restart && state == FLUSH;
  assign tail_step  = !restart && state == TAIL;
  assign step       = accept || flush_step;
  assign col_in[0]  = (accept && cur_row == RW'(1)) ? mid : top;
  assign col_in[1]  = mid;
  assign col_in[2]  = flush_step ? mid : pix_in;
  // Column 0 slot carries the previous row's right-edge window (right column duplicated).
  assign edge_out   = tail_step || (step && cur_col == '0 && (flush_step || cur_row >= RW'(2)));
  assign body_out   = step && cur_col != '0 && (flush_step || cur_row != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) o[i] <= '0;
    end else if (edge_out || body_out) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        o[3*r]   <= w[3*r+1];
        o[3*r+1] <= w[3*r+2];
        o[3*r+2] <= body_out ? col_in[r] : w[3*r+2];
      end
    end
  end

  assign sw = o;
`else
  assign step      = accept;
  assign col_in[0] = top;
  assign col_in[1] = mid;
  assign col_in[2] = pix_in;
  assign body_out  = accept && cur_row >= RW'(2) && cur_col >= CW'(2);
  assign sw        = w;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (restart) state_nxt = FILL;
      FILL:   if (restart) state_nxt = FILL;
              else if (accept && cur_row == RW'(1) && cur_col == COL_LAST) state_nxt = STREAM;
`ifdef WINDOW_BORDER_REPLICATE_EN
      STREAM: if (restart) state_nxt = FILL;
              else if (last) state_nxt = FLUSH;
      FLUSH:  if (restart) state_nxt = FILL;
              else if (col == COL_LAST) state_nxt = TAIL;
      TAIL:   state_nxt = restart ? FILL : IDLE;
`else
      STREAM: if (restart) state_nxt = FILL;
              else if (last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (step) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) w[i] <= '0;
    end else if (step) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        w[3*r] <= w[3*r+1];
`ifdef WINDOW_BORDER_REPLICATE_EN
        // Left clamp: column 0 is loaded twice so column -1 reads as column 0.
        w[3*r+1] <= (cur_col == '0) ? col_in[r] : w[3*r+2];
`else
        w[3*r+1] <= w[3*r+2];
`endif
        w[3*r+2] <= col_in[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win.act <= 1'b0;
      eof     <= 1'b0;
    end else begin
`ifdef WINDOW_BORDER_REPLICATE_EN
      win.act <= body_out || edge_out;
      eof     <= tail_step;
`else
      win.act <= body_out;
      eof     <= last;
`endif
    end
  end

  assign win.sw_pixel_1 = sw[0];
  assign win.sw_pixel_2 = sw[1];
  assign win.sw_pixel_3 = sw[2];
  assign win.sw_pixel_4 = sw[3];
  assign win.sw_pixel_5 = sw[4];
  assign win.sw_pixel_6 = sw[5];
  assign win.sw_pixel_7 = sw[6];
  assign win.sw_pixel_8 = sw[7];
  assign win.sw_pixel_9 = sw[8];
  assign busy           = (state != IDLE);
  assign dbg_state      = state;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 frame where pixel value = row*16+col.
module tb_window_gen_3x3;
  import window_pkg::*;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] pix_in = '0;
  logic       eof, busy;
  state_t     dbg_state;

  window_gen_3x3_if #(.PIX_W(8)) u_if ();

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .win(u_if), .eof(eof), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          act_cnt, eof_cnt, gap_err;
  logic [7:0]  eof_pix;
  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];
  logic [71:0] win_now;

  assign win_now = {u_if.sw_pixel_1, u_if.sw_pixel_2, u_if.sw_pixel_3,
                    u_if.sw_pixel_4, u_if.sw_pixel_5, u_if.sw_pixel_6,
                    u_if.sw_pixel_7, u_if.sw_pixel_8, u_if.sw_pixel_9};

  // Window whose newest pixel is (r,c), packed sw_pixel_1 in the top byte.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[63:0], 8'((r - 2 + i) * 16 + (c - 2 + j))};
    return v;
  endfunction

  task automatic clear();
    act_cnt = 0; eof_cnt = 0; gap_err = 0; eof_pix = '0;
    exp_q.delete(); got_q.delete();
  endtask

  // One clock of stimulus; observes the registered response 1 time unit after the edge.
  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    pix_valid = v; sof = s; pix_in = p;
    @(posedge clk);
    #1;
    if (u_if.act === 1'b1) begin
      got_q.push_back(win_now);
      act_cnt++;
      if (!v) gap_err++;
    end
    if (eof === 1'b1) begin
      eof_cnt++;
      eof_pix = p;
    end
  endtask

  task automatic send_frame(input int duty, input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      while ($urandom_range(0, 99) >= duty) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      drive(1'b1, idx == 0, 8'(r * 16 + c));
      if (r >= 2 && c >= 2) exp_q.push_back(exp_win(r, c));
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pulse_reset(2);
    vectors++; if (u_if.act !== 1'b0) begin miscompares++; $display("FAIL reset_act: got %b expected 0", u_if.act); end
    vectors++; if (eof !== 1'b0) begin miscompares++; $display("FAIL reset_eof: got %b expected 0", eof); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (win_now !== 72'h0) begin miscompares++; $display("FAIL reset_window: got %h expected 0", win_now); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_frame();
    clear();
    send_frame(100, W * H);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    vectors++; if (act_cnt !== 6) begin miscompares++; $display("FAIL full_act_count: got %0d expected 6", act_cnt); end
    vectors++;
    if (got_q.size() == 0 || got_q[0] !== 72'h000102101112202122) begin
      miscompares++; $display("FAIL full_first_window: got %h expected 000102101112202122", got_q.size() ? got_q[0] : 72'hx);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL full_window_%0d: got %h expected %h", i, i < got_q.size() ? got_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++; if (eof_cnt !== 1) begin miscompares++; $display("FAIL full_eof_count: got %0d expected 1", eof_cnt); end
    vectors++; if (eof_pix !== 8'h34) begin miscompares++; $display("FAIL full_eof_after: got %h expected 34", eof_pix); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_row_wrap();
    clear();
    for (int idx = 0; idx < W * H; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      drive(1'b1, idx == 0, 8'(r * 16 + c));
      if (idx == 0) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wrap_busy_start: got %b expected 1", busy); end
      end
      if (r == 3 && c < 2) begin
        vectors++; if (u_if.act !== 1'b0) begin miscompares++; $display("FAIL wrap_act_col%0d: got %b expected 0", c, u_if.act); end
      end
      if (r == 3 && c == 2) begin
        vectors++; if (u_if.act !== 1'b1) begin miscompares++; $display("FAIL wrap_act_32: got %b expected 1", u_if.act); end
        vectors++;
        if (win_now !== 72'h101112202122303132) begin
          miscompares++; $display("FAIL wrap_window_32: got %h expected 101112202122303132", win_now);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_gaps();
    clear();
    send_frame(50, W * H);
    drive(1'b0, 1'b0, 8'h00);
    vectors++; if (act_cnt !== 6) begin miscompares++; $display("FAIL gaps_act_count: got %0d expected 6", act_cnt); end
    vectors++; if (gap_err !== 0) begin miscompares++; $display("FAIL gaps_act_after_idle: got %0d expected 0", gap_err); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL gaps_window_%0d: got %h expected %h", i, i < got_q.size() ? got_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++; if (eof_cnt !== 1) begin miscompares++; $display("FAIL gaps_eof_count: got %0d expected 1", eof_cnt); end
  endtask

  task automatic test_ignore();
    clear();
    for (int i = 0; i < 2 * W; i++) drive(1'b1, 1'b0, 8'(i * 7));
    vectors++; if (act_cnt !== 0) begin miscompares++; $display("FAIL ignore_act_count: got %0d expected 0", act_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_busy: got %b expected 0", busy); end
    clear();
    send_frame(100, W * H);
    drive(1'b0, 1'b0, 8'h00);
    vectors++; if (act_cnt !== 6) begin miscompares++; $display("FAIL second_act_count: got %0d expected 6", act_cnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL second_window_%0d: got %h expected %h", i, i < got_q.size() ? got_q[i] : 72'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_restart();
    // A new sof two rows in discards the partial frame's position.
    clear();
    send_frame(100, 2 * W + 4);
    send_frame(100, W * H);
    drive(1'b0, 1'b0, 8'h00);
    vectors++; if (act_cnt !== 8) begin miscompares++; $display("FAIL restart_act_count: got %0d expected 8", act_cnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL restart_window_%0d: got %h expected %h", i, i < got_q.size() ? got_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++; if (eof_cnt !== 1) begin miscompares++; $display("FAIL restart_eof_count: got %0d expected 1", eof_cnt); end
    // sof on the final pixel restarts instead of ending the frame.
    clear();
    send_frame(100, W * H - 1);
    drive(1'b1, 1'b1, 8'h34);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    vectors++; if (eof_cnt !== 0) begin miscompares++; $display("FAIL final_sof_eof: got %0d expected 0", eof_cnt); end
    vectors++; if (dbg_state !== FILL) begin miscompares++; $display("FAIL final_sof_state: got %0d expected FILL", dbg_state); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL final_sof_busy: got %b expected 1", busy); end
    pulse_reset(1);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear();
    send_frame(100, 2 * W + 4);
    pulse_reset(1);
    vectors++; if (u_if.act !== 1'b0) begin miscompares++; $display("FAIL midrst_act: got %b expected 0", u_if.act); end
    vectors++; if (win_now !== 72'h0) begin miscompares++; $display("FAIL midrst_window: got %h expected 0", win_now); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL midrst_state: got %0d expected IDLE", dbg_state); end
    @(negedge clk); rst = 1'b0;
    clear();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hAA);
    vectors++; if (act_cnt !== 0) begin miscompares++; $display("FAIL midrst_nosof_act: got %0d expected 0", act_cnt); end
    clear();
    send_frame(100, W * H);
    drive(1'b0, 1'b0, 8'h00);
    vectors++;
    if (got_q.size() == 0 || got_q[0] !== 72'h000102101112202122) begin
      miscompares++; $display("FAIL midrst_first_window: got %h expected 000102101112202122", got_q.size() ? got_q[0] : 72'hx);
    end
    vectors++; if (act_cnt !== 6) begin miscompares++; $display("FAIL midrst_act_count: got %0d expected 6", act_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_row_wrap();
    test_gaps();
    test_ignore();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
